// File: rtl/id_regstage.sv
// Decode-stage register block: register file, pending-write scoreboard, link forcing, ID/EX register.
// Optional writeback bypass into reads and hazard detection when ID_BYPASS_EN is defined.
module id_regstage #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned NREGS  = 8,
   parameter int unsigned PEND_W = 2,
   parameter int unsigned PC_W   = 16,
   localparam int unsigned AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [AW-1:0]    in_sr1,
   input  logic [AW-1:0]    in_sr2,
   input  logic             in_use1,
   input  logic             in_use2,
   input  logic [AW-1:0]    in_dest,
   input  logic             in_wr,
   input  logic             in_link,
   input  logic [PC_W-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [AW-1:0]    out_dest,
   output logic             out_wr,
   output logic [PC_W-1:0]  out_pc,
   input  logic             wb_en,
   input  logic [AW-1:0]    wb_dest,
   input  logic [WIDTH-1:0] wb_data,
   input  logic             flush
);

   logic [WIDTH-1:0]  rf_q   [NREGS];
   logic [PEND_W-1:0] pend_q [NREGS];
   logic [PEND_W-1:0] pend_d [NREGS];

   logic              out_valid_q, out_wr_q;
   logic [WIDTH-1:0]  out_a_q, out_b_q;
   logic [AW-1:0]     out_dest_q;
   logic [PC_W-1:0]   out_pc_q;

   logic [AW-1:0]     dest_r;
   logic              wr_r, busy1, busy2, full, hazard, accept;
   logic [WIDTH-1:0]  rd_a, rd_b;

   assign dest_r = in_link ? AW'(NREGS - 1) : in_dest;
   assign wr_r   = in_wr | in_link;
   assign full   = pend_q[dest_r] == {PEND_W{1'b1}};

   always_comb begin
      rd_a  = rf_q[in_sr1];
      rd_b  = rf_q[in_sr2];
      busy1 = pend_q[in_sr1] != '0;
      busy2 = pend_q[in_sr2] != '0;
`ifdef ID_BYPASS_EN
      if (wb_en && (wb_dest == in_sr1)) rd_a = wb_data;
      if (wb_en && (wb_dest == in_sr2)) rd_b = wb_data;
      // The last outstanding writeback releases the stall in its own cycle.
      busy1 = pend_q[in_sr1] > PEND_W'(wb_en && (wb_dest == in_sr1));
      busy2 = pend_q[in_sr2] > PEND_W'(wb_en && (wb_dest == in_sr2));
`endif
   end

   assign hazard   = (in_use1 & busy1) | (in_use2 & busy2) | (wr_r & full);
   assign in_ready = (!out_valid_q | out_ready) & !hazard & !flush;
   assign accept   = in_valid & in_ready;

   always_comb begin
      logic              inc, dec, fdec;
      logic [PEND_W-1:0] cnt;
      inc  = 1'b0;
      dec  = 1'b0;
      fdec = 1'b0;
      cnt  = '0;
      for (int r = 0; r < NREGS; r++) begin
         inc  = accept && wr_r && (dest_r == AW'(r));
         dec  = wb_en && (wb_dest == AW'(r));
         fdec = flush && out_valid_q && out_wr_q && (out_dest_q == AW'(r));
         cnt  = pend_q[r];
         if (inc && !dec) cnt = cnt + 1'b1;
         else if (!inc && dec && (cnt != '0)) cnt = cnt - 1'b1;
         if (fdec && (cnt != '0)) cnt = cnt - 1'b1;
         pend_d[r] = cnt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_q        <= '{default: '0};
         pend_q      <= '{default: '0};
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_dest_q  <= '0;
         out_wr_q    <= 1'b0;
         out_pc_q    <= '0;
      end else begin
         if (wb_en) rf_q[wb_dest] <= wb_data;
         pend_q <= pend_d;
         if (flush) begin
            out_valid_q <= 1'b0;
         end else if (accept) begin
            out_valid_q <= 1'b1;
            out_a_q     <= rd_a;
            out_b_q     <= rd_b;
            out_dest_q  <= dest_r;
            out_wr_q    <= wr_r;
            out_pc_q    <= in_pc;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_dest  = out_dest_q;
   assign out_wr    = out_wr_q;
   assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_id_regstage.sv
// Directed bench for id_regstage: operand vector table plus hazard, link, backpressure,
// scoreboard saturation, flush and reset sequences.
module tb_id_regstage;
   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, in_use1, in_use2, in_wr, in_link;
   logic [2:0]  in_sr1, in_sr2, in_dest, out_dest, wb_dest;
   logic [15:0] in_pc, out_a, out_b, out_pc, wb_data;
   logic        out_valid, out_ready, out_wr, wb_en, flush;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [2:0]  sr1, sr2, dest;
      logic [15:0] pc, ea, eb;
   } vec_t;
   vec_t vecs [5];

   id_regstage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_sr1(in_sr1), .in_sr2(in_sr2), .in_use1(in_use1), .in_use2(in_use2),
      .in_dest(in_dest), .in_wr(in_wr), .in_link(in_link), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .out_dest(out_dest), .out_wr(out_wr), .out_pc(out_pc),
      .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .flush(flush)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      in_valid = 0; in_use1 = 0; in_use2 = 0; in_wr = 0; in_link = 0;
      wb_en = 0; flush = 0;
   endtask

   task automatic wb(input logic [2:0] r, input logic [15:0] d);
      wb_en = 1; wb_dest = r; wb_data = d;
      tick;
      wb_en = 0;
   endtask

   task automatic instr(input logic [2:0] s1, input logic u1, input logic [2:0] s2,
                        input logic u2, input logic [2:0] d, input logic w,
                        input logic l, input logic [15:0] pc);
      in_valid = 1; in_sr1 = s1; in_use1 = u1; in_sr2 = s2; in_use2 = u2;
      in_dest = d; in_wr = w; in_link = l; in_pc = pc;
   endtask

   initial begin
      vecs[0] = '{sr1: 3'd3, sr2: 3'd0, dest: 3'd2, pc: 16'h0100, ea: 16'h1234, eb: 16'h0F0F};
      vecs[1] = '{sr1: 3'd7, sr2: 3'd5, dest: 3'd6, pc: 16'h0102, ea: 16'h7777, eb: 16'h5555};
      vecs[2] = '{sr1: 3'd0, sr2: 3'd0, dest: 3'd0, pc: 16'h0104, ea: 16'h0F0F, eb: 16'h0F0F};
      vecs[3] = '{sr1: 3'd1, sr2: 3'd6, dest: 3'd7, pc: 16'h0106, ea: 16'h1111, eb: 16'h6666};
      vecs[4] = '{sr1: 3'd4, sr2: 3'd2, dest: 3'd3, pc: 16'hFFFE, ea: 16'h4444, eb: 16'h2222};

      idle;
      in_sr1 = 0; in_sr2 = 0; in_dest = 0; in_pc = 0; wb_dest = 0; wb_data = 0;
      out_ready = 1; rst_n = 0;
      tick; tick;
      chk("rst_valid", {31'd0, out_valid}, 0);
      chk("rst_a", {16'd0, out_a}, 0);
      chk("rst_b", {16'd0, out_b}, 0);
      chk("rst_dest", {29'd0, out_dest}, 0);
      chk("rst_wr", {31'd0, out_wr}, 0);
      chk("rst_pc", {16'd0, out_pc}, 0);
      rst_n = 1;

      wb(3'd0, 16'h0F0F); wb(3'd1, 16'h1111); wb(3'd2, 16'h2222); wb(3'd3, 16'h1234);
      wb(3'd4, 16'h4444); wb(3'd5, 16'h5555); wb(3'd6, 16'h6666); wb(3'd7, 16'h7777);

      // Back-to-back operand reads with no writes.
      for (int i = 0; i < 5; i++) begin
         instr(vecs[i].sr1, 1, vecs[i].sr2, 1, vecs[i].dest, 0, 0, vecs[i].pc);
         #1;
         chk("vec_ready", {31'd0, in_ready}, 1);
         tick;
         chk("vec_valid", {31'd0, out_valid}, 1);
         chk("vec_a", {16'd0, out_a}, {16'd0, vecs[i].ea});
         chk("vec_b", {16'd0, out_b}, {16'd0, vecs[i].eb});
         chk("vec_dest", {29'd0, out_dest}, {29'd0, vecs[i].dest});
         chk("vec_wr", {31'd0, out_wr}, 0);
         chk("vec_pc", {16'd0, out_pc}, {16'd0, vecs[i].pc});
      end
      idle; tick;
      chk("drain_valid", {31'd0, out_valid}, 0);

      // RAW on R2.
      instr(0, 0, 0, 0, 3'd2, 1, 0, 16'h0200);
      #1; chk("raw_wr_ready", {31'd0, in_ready}, 1);
      tick;
      instr(0, 0, 3'd2, 1, 3'd0, 0, 0, 16'h0202);
      #1; chk("raw_stall0", {31'd0, in_ready}, 0);
      tick;
      chk("raw_stall1", {31'd0, in_ready}, 0);
      wb_en = 1; wb_dest = 3'd2; wb_data = 16'hBEEF;
      #1;
`ifdef ID_BYPASS_EN
      chk("raw_wb_ready", {31'd0, in_ready}, 1);
      tick; wb_en = 0;
`else
      chk("raw_wb_ready", {31'd0, in_ready}, 0);
      tick; wb_en = 0;
      chk("raw_after_valid", {31'd0, out_valid}, 0);
      #1; chk("raw_after_ready", {31'd0, in_ready}, 1);
      tick;
`endif
      chk("raw_valid", {31'd0, out_valid}, 1);
      chk("raw_b", {16'd0, out_b}, 16'hBEEF);
      chk("raw_pc", {16'd0, out_pc}, 16'h0202);
      idle; tick;

      // Link forcing to R7.
      instr(0, 0, 0, 0, 3'd1, 0, 1, 16'h0300);
      tick;
      chk("link_dest", {29'd0, out_dest}, 7);
      chk("link_wr", {31'd0, out_wr}, 1);
      instr(3'd7, 1, 0, 0, 0, 0, 0, 16'h0302);
      #1; chk("link_pend7", {31'd0, in_ready}, 0);
      in_sr1 = 3'd1;
      #1; chk("link_pend1", {31'd0, in_ready}, 1);
      tick;
      idle;
      wb(3'd7, 16'h7777);
      tick;

      // Backpressure hold.
      out_ready = 0;
      instr(3'd4, 1, 0, 0, 0, 0, 0, 16'h0400);
      tick;
      instr(3'd5, 1, 0, 0, 0, 0, 0, 16'h0402);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_ready", {31'd0, in_ready}, 0);
         chk("hold_valid", {31'd0, out_valid}, 1);
         chk("hold_a", {16'd0, out_a}, 16'h4444);
         chk("hold_pc", {16'd0, out_pc}, 16'h0400);
         tick;
      end
      out_ready = 1;
      #1; chk("release_ready", {31'd0, in_ready}, 1);
      tick;
      chk("release_pc", {16'd0, out_pc}, 16'h0402);
      chk("release_a", {16'd0, out_a}, 16'h5555);
      idle; tick;

      // Scoreboard saturation on R5.
      for (int i = 0; i < 3; i++) begin
         instr(0, 0, 0, 0, 3'd5, 1, 0, 16'(16'h0500 + 2 * i));
         #1; chk("sat_ready", {31'd0, in_ready}, 1);
         tick;
      end
      instr(0, 0, 0, 0, 3'd5, 1, 0, 16'h0506);
      #1; chk("sat_full0", {31'd0, in_ready}, 0);
      tick;
      chk("sat_full1", {31'd0, in_ready}, 0);
      wb_en = 1; wb_dest = 3'd5; wb_data = 16'h5A5A;
      #1; chk("sat_full_wb", {31'd0, in_ready}, 0);
      tick; wb_en = 0;
      #1; chk("sat_after_wb", {31'd0, in_ready}, 1);
      tick;
      chk("sat_pc", {16'd0, out_pc}, 16'h0506);
      #1; chk("sat_refull", {31'd0, in_ready}, 0);
      idle;
      wb(3'd5, 16'h5A5A); wb(3'd5, 16'h5A5A); wb(3'd5, 16'h5A5A);
      instr(3'd5, 1, 0, 0, 0, 0, 0, 16'h0508);
      #1; chk("sat_drained", {31'd0, in_ready}, 1);
      idle; tick;

      // Flush a held write to R4.
      out_ready = 0;
      instr(0, 0, 0, 0, 3'd4, 1, 0, 16'h0600);
      tick;
      idle; flush = 1;
      #1; chk("flush_ready", {31'd0, in_ready}, 0);
      tick; flush = 0;
      chk("flush_valid", {31'd0, out_valid}, 0);
      instr(3'd4, 1, 0, 0, 0, 0, 0, 16'h0602);
      #1; chk("flush_pend4", {31'd0, in_ready}, 1);
      tick;
      chk("flush_next_a", {16'd0, out_a}, 16'h4444);

      // Reset while stalled behind a held instruction.
      instr(3'd6, 1, 0, 0, 0, 0, 0, 16'h0700);
      #1; chk("pre_rst_stall", {31'd0, in_ready}, 0);
      rst_n = 0;
      tick;
      rst_n = 1; idle;
      chk("mrst_valid", {31'd0, out_valid}, 0);
      chk("mrst_a", {16'd0, out_a}, 0);
      chk("mrst_pc", {16'd0, out_pc}, 0);
      chk("mrst_dest", {29'd0, out_dest}, 0);
      chk("mrst_wr", {31'd0, out_wr}, 0);
      out_ready = 1;
      instr(3'd4, 1, 3'd3, 1, 0, 0, 0, 16'h0800);
      tick;
      idle;
      chk("mrst_rf_a", {16'd0, out_a}, 0);
      chk("mrst_rf_b", {16'd0, out_b}, 0);
      tick;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/id_regstage.md
Name: id_regstage

Overview:
- Parametrised decode-stage register block for the pipelined LC-3b core.
- Contains the register file, a per-register pending-write scoreboard, link-register destination forcing and the ID/EX pipeline register.
- Generates load-use/RAW stalls and holds results under valid/ready handshakes on both sides.
- Sits between IF/ID and EX; takes writebacks from WB.

Parameters:
WIDTH, 16, register and data width in bits
NREGS, 8, number of architectural registers (power of two, >=2); AW = clog2(NREGS)
PEND_W, 2, width of each scoreboard pending counter
PC_W, 16, width of carried PC

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  decoded instruction available from IF/ID
in_ready  out  1  block accepts instruction this cycle
in_sr1  in  AW  source register 1 index
in_sr2  in  AW  source register 2 index
in_use1  in  1  instruction reads sr1
in_use2  in  1  instruction reads sr2
in_dest  in  AW  destination index
in_wr  in  1  instruction writes a register
in_link  in  1  force destination to NREGS-1 (JSR/TRAP)
in_pc  in  PC_W  instruction PC
out_valid  out  1  ID/EX register holds an instruction
out_ready  in  1  EX accepts
out_a  out  WIDTH  sr1 operand value
out_b  out  WIDTH  sr2 operand value
out_dest  out  AW  resolved destination
out_wr  out  1  resolved write enable
out_pc  out  PC_W  carried PC
wb_en  in  1  writeback strobe
wb_dest  in  AW  writeback index
wb_data  in  WIDTH  writeback data
flush  in  1  kill ID/EX contents

Behaviour:
- Reset (rst_n=0 at posedge): all registers = 0, all pending counters = 0, out_valid = 0, out_a/out_b/out_dest/out_wr/out_pc = 0. Reset mid-stall discards the held instruction.
- Destination resolution: dest_r = in_link ? NREGS-1 : in_dest. out_wr = in_wr | in_link.
- Register file:
  - Write on wb_en at posedge.
  - Reads are combinational.
  - Write-first bypass applies only when the optional feature is enabled (see below).
- Scoreboard:
  - pend[r] increments when an instruction with resolved write to r is accepted (in_valid & in_ready).
  - pend[r] decrements on wb_en to r, saturating at 0.
  - Accept and writeback to the same r in one cycle: count unchanged.
- Hazard (combinational): stall if
  - (in_use1 & busy(in_sr1)), or
  - (in_use2 & busy(in_sr2)), or
  - (resolved write & pend[dest_r] == max).
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Pipeline register:
  - Loads on accept; latency 1 cycle from accept to out_valid.
  - Holds all outputs stable while out_valid & !out_ready.
  - Clears out_valid when out_ready & !accept.
- Flush:
  - At posedge, clear out_valid.
  - If the flushed entry had out_wr, decrement pend[out_dest].
  - No accept occurs that cycle.
  - Flush overrides simultaneous out_ready.
- Register 0 is a normal writable register.

Optional Feature:
ID_BYPASS_EN
- Defined:
  - Reading register r while wb_en & wb_dest==r returns wb_data.
  - busy(r) = pend[r] > (wb_en & wb_dest==r ? 1 : 0), so the final writeback releases the stall in the same cycle.
- Undefined:
  - Reads return stored array value.
  - busy(r) = pend[r] != 0.
  - A RAW stall lasts one extra cycle after writeback.

Test Plan:
- Reset, then R3 written 0x1234 via wb; accept sr1=3 -> next cycle out_valid=1, out_a=0x1234.
- Accept wr R2 (pend[2]=1), then instruction using sr2=2 -> in_ready=0 until wb_en to R2 with 0xBEEF. With ID_BYPASS_EN: accept in the wb cycle, out_b=0xBEEF. Without: accept the cycle after.
- in_link=1, in_dest=1 -> out_dest=7, out_wr=1, pend[7]=1; pend[1] unchanged.
- out_ready=0 for 3 cycles with out_valid=1 -> outputs constant, in_ready=0. Then out_ready=1 -> next instruction accepted.
- Three accepted writes to R5 with PEND_W=2 -> pend[5]=3; a fourth write to R5 stalls. One wb to R5 -> fourth accepted, pend[5]=3.
- Flush with held write-instruction to R4 (pend[4]=1) -> out_valid=0 and pend[4]=0 next cycle. rst_n=0 during a stall -> all outputs 0.
